// File: rtl/shared_fu_arbiter_pkg.sv
// Shared functional-unit arbiter: common types and sizing helpers.
// Optional build macro used by this block: SHARED_FU_ARB_PERF_EN (performance counters).
package shared_fu_arbiter_pkg;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // Width of the port-select index; at least one bit so a 1-port build still elaborates.
  function automatic int shared_fu_sel_w(input int nr_req);
    return (nr_req > 1) ? $clog2(nr_req) : 1;
  endfunction

  // Width of the watchdog counter, large enough to hold lat_max itself.
  function automatic int shared_fu_cnt_w(input int lat_max);
    return $clog2(lat_max + 1);
  endfunction

  localparam int SHARED_FU_NR_REQ_DEF = 2;
  localparam int SHARED_FU_SEL_W      = shared_fu_sel_w(SHARED_FU_NR_REQ_DEF);

endpackage

// File: rtl/shared_fu_arbiter_if.sv
// Handshake bundle between issue ports, the shared FU and the writeback path.
// Signal suffixes are from the arbiter's point of view (slave modport).
// With SHARED_FU_ARB_PERF_EN defined, the performance counter outputs are carried here too.
interface shared_fu_arbiter_if
  import shared_fu_arbiter_pkg::*;
#(
  parameter int NR_REQ        = 2,
  parameter int TRANS_ID_BITS = 3
);
  localparam int SEL_W = shared_fu_sel_w(NR_REQ);

  logic                            flush_i;
  logic [NR_REQ-1:0]               req_valid_i;
  logic [NR_REQ*TRANS_ID_BITS-1:0] req_trans_id_i;
  logic [NR_REQ-1:0]               req_ready_o;
  logic                            fu_ready_i;
  logic                            fu_valid_o;
  logic [SEL_W-1:0]                fu_sel_o;
  logic                            fu_kill_o;
  logic                            fu_done_i;
  logic                            wb_valid_o;
  logic [TRANS_ID_BITS-1:0]        wb_trans_id_o;
  logic                            busy_o;
  logic                            timeout_o;
`ifdef SHARED_FU_ARB_PERF_EN
  logic [31:0]                     contention_cnt_o;
  logic [NR_REQ*16-1:0]            grant_cnt_o;
`endif

  modport slave (
`ifdef SHARED_FU_ARB_PERF_EN
    output contention_cnt_o,
    output grant_cnt_o,
`endif
    input  flush_i,
    input  req_valid_i,
    input  req_trans_id_i,
    output req_ready_o,
    input  fu_ready_i,
    output fu_valid_o,
    output fu_sel_o,
    output fu_kill_o,
    input  fu_done_i,
    output wb_valid_o,
    output wb_trans_id_o,
    output busy_o,
    output timeout_o
  );

  modport master (
`ifdef SHARED_FU_ARB_PERF_EN
    input  contention_cnt_o,
    input  grant_cnt_o,
`endif
    output flush_i,
    output req_valid_i,
    output req_trans_id_i,
    input  req_ready_o,
    output fu_ready_i,
    input  fu_valid_o,
    input  fu_sel_o,
    input  fu_kill_o,
    output fu_done_i,
    input  wb_valid_o,
    input  wb_trans_id_o,
    input  busy_o,
    input  timeout_o
  );

endinterface

// File: rtl/shared_fu_arbiter_rr_arbiter_oh.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping to the bottom, returned both one-hot and as an index.
module rr_arbiter_oh
  import shared_fu_arbiter_pkg::*;
#(
  parameter int NR_REQ = 2,
  localparam int SEL_W = shared_fu_sel_w(NR_REQ)
) (
  input  logic [NR_REQ-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic [NR_REQ-1:0] gnt_oh_o,
  output logic [SEL_W-1:0]  gnt_idx_o,
  output logic              gnt_any_o
);

  // Two passes: upper segment [ptr, NR_REQ) first, then wrapped segment [0, ptr).
  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (!gnt_any_o && req_i[i] && (i >= int'(ptr_i))) begin
        gnt_oh_o[i] = 1'b1;
        gnt_idx_o   = SEL_W'(i);
        gnt_any_o   = 1'b1;
      end else begin
        gnt_any_o   = gnt_any_o;
      end
    end
    for (int i = 0; i < NR_REQ; i++) begin
      if (!gnt_any_o && req_i[i] && (i < int'(ptr_i))) begin
        gnt_oh_o[i] = 1'b1;
        gnt_idx_o   = SEL_W'(i);
        gnt_any_o   = 1'b1;
      end else begin
        gnt_any_o   = gnt_any_o;
      end
    end
  end

endmodule

// File: rtl/shared_fu_arbiter.sv
// Shares one non-pipelined multi-cycle FU between NR_REQ issue ports.
// Round-robin grant, in-flight ID capture, flush drain/kill and a sticky watchdog.
// Optional build macro: SHARED_FU_ARB_PERF_EN adds contention and per-port grant counters.
module shared_fu_arbiter
  import shared_fu_arbiter_pkg::*;
#(
  parameter int NR_REQ        = 2,
  parameter int TRANS_ID_BITS = 3,
  parameter int LAT_MAX       = 64
) (
  input  logic                clk_i,
  input  logic                rst_i,
  shared_fu_arbiter_if.slave  bus
);

  localparam int SEL_W = shared_fu_sel_w(NR_REQ);
  localparam int CNT_W = shared_fu_cnt_w(LAT_MAX);
  localparam logic [CNT_W-1:0] LAT_MAX_C = CNT_W'(LAT_MAX);
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NR_REQ - 1);

  arb_state_e               state_q, state_d;
  logic [SEL_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [TRANS_ID_BITS-1:0] id_q, id_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     timeout_q, timeout_d;

  logic [NR_REQ-1:0]        gnt_oh_s;
  logic [SEL_W-1:0]         gnt_idx_s;
  logic                     gnt_any_s;
  logic                     grant_s;
  logic [TRANS_ID_BITS-1:0] gnt_id_s;

  rr_arbiter_oh #(
    .NR_REQ (NR_REQ)
  ) u_rr (
    .req_i     (bus.req_valid_i),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (gnt_oh_s),
    .gnt_idx_o (gnt_idx_s),
    .gnt_any_o (gnt_any_s)
  );

  // A grant only happens from IDLE, with the FU ready and no flush pending.
  always_comb begin
    if ((state_q == IDLE) && !bus.flush_i && bus.fu_ready_i && gnt_any_s) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Pick the transaction ID of the granted port.
  always_comb begin
    gnt_id_s = '0;
    for (int i = 0; i < NR_REQ; i++) begin
      if (gnt_oh_s[i]) begin
        gnt_id_s = bus.req_trans_id_i[i*TRANS_ID_BITS +: TRANS_ID_BITS];
      end else begin
        gnt_id_s = gnt_id_s;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          state_d = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (bus.fu_done_i) begin
          state_d = IDLE;
        end else if (bus.flush_i) begin
          state_d = DRAIN;
        end else begin
          state_d = BUSY;
        end
      end
      DRAIN: begin
        if (bus.fu_done_i) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM outputs: same-cycle grant handshake, completion steering and kill pulse.
  always_comb begin
    bus.req_ready_o   = '0;
    bus.fu_valid_o    = 1'b0;
    bus.fu_sel_o      = '0;
    bus.fu_kill_o     = 1'b0;
    bus.wb_valid_o    = 1'b0;
    bus.wb_trans_id_o = '0;
    bus.busy_o        = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_s) begin
          bus.req_ready_o = gnt_oh_s;
          bus.fu_valid_o  = 1'b1;
          bus.fu_sel_o    = gnt_idx_s;
        end else begin
          bus.fu_valid_o  = 1'b0;
        end
      end
      BUSY: begin
        bus.busy_o        = 1'b1;
        bus.wb_trans_id_o = id_q;
        bus.wb_valid_o    = bus.fu_done_i & ~bus.flush_i;
        bus.fu_kill_o     = bus.flush_i & ~bus.fu_done_i;
      end
      DRAIN: begin
        bus.busy_o        = 1'b1;
        bus.wb_trans_id_o = id_q;
      end
      default: begin
        bus.busy_o        = 1'b0;
      end
    endcase
  end

  // Next values for pointer, captured ID, watchdog counter and sticky timeout.
  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (grant_s) begin
      rr_ptr_d = (gnt_idx_s == LAST_IDX) ? '0 : gnt_idx_s + SEL_W'(1);
      id_d     = gnt_id_s;
      cnt_d    = '0;
    end else if (state_q != IDLE) begin
      cnt_d = (cnt_q == LAT_MAX_C) ? cnt_q : cnt_q + CNT_W'(1);
      // Only an operation still outstanding next cycle can be declared overdue.
      if ((state_d != IDLE) && (cnt_d == LAT_MAX_C)) begin
        timeout_d = 1'b1;
      end else begin
        timeout_d = timeout_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Datapath registers; reset abandons any operation without a kill.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q  <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout_o = timeout_q;

`ifdef SHARED_FU_ARB_PERF_EN
  logic [31:0]          contention_q;
  logic [NR_REQ*16-1:0] grant_cnt_q;

  // Performance counters: cycles lost to contention and per-port grants; flush leaves them alone.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      contention_q <= 32'd0;
      grant_cnt_q  <= '0;
    end else begin
      if ((|bus.req_valid_i) && !grant_s) begin
        contention_q <= contention_q + 32'd1;
      end else begin
        contention_q <= contention_q;
      end
      for (int i = 0; i < NR_REQ; i++) begin
        if (grant_s && gnt_oh_s[i]) begin
          grant_cnt_q[i*16 +: 16] <= grant_cnt_q[i*16 +: 16] + 16'd1;
        end else begin
          grant_cnt_q[i*16 +: 16] <= grant_cnt_q[i*16 +: 16];
        end
      end
    end
  end

  assign bus.contention_cnt_o = contention_q;
  assign bus.grant_cnt_o      = grant_cnt_q;
`endif

endmodule

// File: tb/tb_shared_fu_arbiter.sv
// Directed, table-driven bench for shared_fu_arbiter (NR_REQ=2, TRANS_ID_BITS=3, LAT_MAX=8).
module tb_shared_fu_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  shared_fu_arbiter_if #(.NR_REQ(2), .TRANS_ID_BITS(3)) bus ();

  shared_fu_arbiter #(
    .NR_REQ        (2),
    .TRANS_ID_BITS (3),
    .LAT_MAX       (8)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       flush;
    logic [1:0] req;
    logic [2:0] id0;
    logic [2:0] id1;
    logic       rdy;
    logic       done;
    logic [1:0] e_ready;
    logic       e_fv;
    logic       e_sel;
    logic       e_kill;
    logic       e_wbv;
    logic [2:0] e_wbid;
    logic       e_busy;
  } vec_t;

  localparam int NV = 33;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic flush, input logic [1:0] req, input logic [2:0] id0,
                       input logic [2:0] id1, input logic rdy, input logic done);
    bus.flush_i        = flush;
    bus.req_valid_i    = req;
    bus.req_trans_id_i = {id1, id0};
    bus.fu_ready_i     = rdy;
    bus.fu_done_i      = done;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    //           flush req    id0   id1   rdy   done  | ready  fv    sel   kill  wbv   wbid  busy
    // single request, done on the 4th BUSY cycle
    vec[0]  = '{1'b0, 2'b01, 3'd5, 3'd0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vec[1]  = '{1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1};
    vec[2]  = '{1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1};
    vec[3]  = '{1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd5, 1'b1};
    vec[4]  = '{1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b1};
    // both ports requesting: pointer is at port 1 after the first grant
    vec[5]  = '{1'b0, 2'b11, 3'd1, 3'd2, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    vec[6]  = '{1'b0, 2'b11, 3'd1, 3'd2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1};
    vec[7]  = '{1'b0, 2'b11, 3'd1, 3'd2, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1};
    vec[8]  = '{1'b0, 2'b11, 3'd1, 3'd2, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vec[9]  = '{1'b0, 2'b11, 3'd1, 3'd2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
    vec[10] = '{1'b0, 2'b11, 3'd1, 3'd2, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1};
    vec[11] = '{1'b0, 2'b11, 3'd1, 3'd2, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    vec[12] = '{1'b0, 2'b11, 3'd1, 3'd2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 1'b1};
    vec[13] = '{1'b0, 2'b11, 3'd1, 3'd2, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b1};
    vec[14] = '{1'b0, 2'b11, 3'd1, 3'd2, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vec[15] = '{1'b0, 2'b11, 3'd1, 3'd2, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
    vec[16] = '{1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd1, 1'b1};
    // backpressure: FU not ready for 3 cycles
    vec[17] = '{1'b0, 2'b10, 3'd0, 3'd4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vec[18] = '{1'b0, 2'b10, 3'd0, 3'd4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vec[19] = '{1'b0, 2'b10, 3'd0, 3'd4, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vec[20] = '{1'b0, 2'b10, 3'd0, 3'd4, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    vec[21] = '{1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1};
    vec[22] = '{1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1};
    // flush in flight: kill, drain, done discarded, then an immediate new grant
    vec[23] = '{1'b0, 2'b01, 3'd3, 3'd0, 1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vec[24] = '{1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1};
    vec[25] = '{1'b1, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 1'b1};
    vec[26] = '{1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1};
    vec[27] = '{1'b0, 2'b10, 3'd0, 3'd6, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 1'b1};
    vec[28] = '{1'b0, 2'b10, 3'd0, 3'd6, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0};
    // flush coincident with done: discarded, no kill, straight back to IDLE
    vec[29] = '{1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1};
    vec[30] = '{1'b1, 2'b00, 3'd0, 3'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1};
    // flush in IDLE blocks the grant; spurious done in IDLE is ignored
    vec[31] = '{1'b1, 2'b01, 3'd2, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};
    vec[32] = '{1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0};

    // reset state
    rst = 1'b1;
    drive(1'b0, 2'b00, 3'd0, 3'd0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset busy",    32'(bus.busy_o), 32'd0);
    chk("reset timeout", 32'(bus.timeout_o), 32'd0);
    chk("reset wbv",     32'(bus.wb_valid_o), 32'd0);
    chk("reset wbid",    32'(bus.wb_trans_id_o), 32'd0);
    chk("reset fv",      32'(bus.fu_valid_o), 32'd0);
    chk("reset kill",    32'(bus.fu_kill_o), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // table-driven cycles
    for (int r = 0; r < NV; r++) begin
      if (r != 0) begin
        @(negedge clk);
      end else begin
        #0;
      end
      drive(vec[r].flush, vec[r].req, vec[r].id0, vec[r].id1, vec[r].rdy, vec[r].done);
      #1;
      chk($sformatf("row%0d ready", r), 32'(bus.req_ready_o), 32'(vec[r].e_ready));
      chk($sformatf("row%0d fu_valid", r), 32'(bus.fu_valid_o), 32'(vec[r].e_fv));
      if (vec[r].e_fv) begin
        chk($sformatf("row%0d fu_sel", r), 32'(bus.fu_sel_o), 32'(vec[r].e_sel));
      end else begin
        n_checks = n_checks;
      end
      chk($sformatf("row%0d kill", r), 32'(bus.fu_kill_o), 32'(vec[r].e_kill));
      chk($sformatf("row%0d wb_valid", r), 32'(bus.wb_valid_o), 32'(vec[r].e_wbv));
      chk($sformatf("row%0d wb_id", r), 32'(bus.wb_trans_id_o), 32'(vec[r].e_wbid));
      chk($sformatf("row%0d busy", r), 32'(bus.busy_o), 32'(vec[r].e_busy));
      chk($sformatf("row%0d timeout", r), 32'(bus.timeout_o), 32'd0);
    end

    // watchdog: grant port 0 and never complete
    @(negedge clk);
    drive(1'b0, 2'b01, 3'd7, 3'd0, 1'b1, 1'b0);
    #1;
    chk("wd grant", 32'(bus.req_ready_o), 32'b01);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1'b0, 2'b00, 3'd0, 3'd0, 1'b1, 1'b0);
      #1;
      chk($sformatf("wd busy c%0d", k), 32'(bus.busy_o), 32'd1);
      chk($sformatf("wd timeout c%0d", k), 32'(bus.timeout_o), (k >= 8) ? 32'd1 : 32'd0);
      chk($sformatf("wd wbid c%0d", k), 32'(bus.wb_trans_id_o), 32'd7);
    end

    // asynchronous reset mid-BUSY, away from any clock edge
    #2;
    rst = 1'b1;
    #1;
    chk("arst busy",    32'(bus.busy_o), 32'd0);
    chk("arst timeout", 32'(bus.timeout_o), 32'd0);
    chk("arst wbid",    32'(bus.wb_trans_id_o), 32'd0);
    chk("arst wbv",     32'(bus.wb_valid_o), 32'd0);
    chk("arst kill",    32'(bus.fu_kill_o), 32'd0);
    chk("arst ready",   32'(bus.req_ready_o), 32'd0);

    // pointer restarts at port 0 after reset
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0, 2'b11, 3'd1, 3'd2, 1'b1, 1'b0);
    #1;
    chk("post-reset ready", 32'(bus.req_ready_o), 32'b01);
    chk("post-reset sel",   32'(bus.fu_sel_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shared_fu_arbiter.md
Name: shared_fu_arbiter

Overview:
Shares one non-pipelined, multi-cycle functional unit (divider or CVXIF-style coprocessor slot) between the issue ports of the issue stage.
- Grants one issue port per FU operation, round-robin.
- Tracks the in-flight transaction ID and steers the FU completion to the writeback path.
- Drains and discards an in-flight operation on flush.
- Sits between issue_read_operands' per-port valid outputs and the shared FU in the execute stage.

Parameters:
NR_REQ, 2, number of requesting issue ports (≥2)
TRANS_ID_BITS, 3, scoreboard transaction ID width
LAT_MAX, 64, watchdog limit in cycles for one FU operation (≥2)

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous active-high reset
flush_i  in  1  flush unissued/in-flight work (controller)
req_valid_i  in  NR_REQ  per-port request to use the shared FU
req_trans_id_i  in  NR_REQ*TRANS_ID_BITS  transaction ID per port
req_ready_o  out  NR_REQ  one-hot grant, same cycle as accepted request
fu_ready_i  in  1  FU can accept an operation
fu_valid_o  out  1  operation launched to the FU
fu_sel_o  out  $clog2(NR_REQ)  index of the port whose operands drive the FU
fu_kill_o  out  1  one-cycle pulse to abort the in-flight FU operation
fu_done_i  in  1  FU result valid (single-cycle pulse)
wb_valid_o  out  1  result valid toward a writeback port
wb_trans_id_o  out  TRANS_ID_BITS  ID of the completing operation
busy_o  out  1  FSM not IDLE
timeout_o  out  1  sticky: watchdog expired

Behaviour:
- Reset (rst_i=1, async):
  - State IDLE; rr_ptr=0; id_q=0; cnt=0.
  - All outputs 0, including timeout_o.
  - Reset mid-operation abandons the operation silently; no fu_kill_o is issued.
- Three states: IDLE, BUSY, DRAIN.
- IDLE, grant condition is !flush_i & fu_ready_i & |req_valid_i:
  - Selects the first set bit of req_valid_i, searching from rr_ptr upward with wrap-around.
  - Same cycle (combinational): req_ready_o[g]=1, fu_valid_o=1, fu_sel_o=g.
  - Next cycle: id_q ← req_trans_id_i[g]; rr_ptr ← (g+1) mod NR_REQ; cnt ← 0; state ← BUSY.
  - Otherwise req_ready_o=0 and fu_valid_o=0.
- BUSY:
  - No grants; cnt increments, saturating at LAT_MAX.
  - fu_done_i & !flush_i: wb_valid_o=1 and wb_trans_id_o=id_q in the same cycle; state ← IDLE.
  - Next grant is no earlier than the following cycle (one-cycle bubble by design).
  - flush_i & !fu_done_i: fu_kill_o=1 for this cycle; state ← DRAIN.
  - flush_i & fu_done_i together: result is discarded (wb_valid_o=0); state ← IDLE; no kill.
  - cnt reaching LAT_MAX sets timeout_o. It stays set until reset; the FSM keeps waiting.
- DRAIN:
  - Waits for fu_done_i, suppressing wb_valid_o; state ← IDLE on fu_done_i.
  - flush_i in DRAIN has no additional effect.
  - The watchdog also runs in DRAIN.
- wb_trans_id_o is driven with id_q whenever not IDLE; it is meaningful only when wb_valid_o=1.
- fu_done_i in IDLE is ignored (spurious).
- busy_o = (state != IDLE).

Optional Feature:
SHARED_FU_ARB_PERF_EN
- Defined:
  - Adds output contention_cnt_o[31:0]. It increments each cycle in which |req_valid_i is set and no grant occurs, and wraps at 2^32.
  - Adds output grant_cnt_o[NR_REQ*16-1:0]: per-port 16-bit grant counters, wrapping.
  - All counters reset to 0 on rst_i and are unaffected by flush_i.
- Undefined: these ports and counters do not exist.

Decomposition:
- Package constants/types:
  - arb_state_e (IDLE, BUSY, DRAIN).
  - SHARED_FU_SEL_W = $clog2(NR_REQ), via a function or localparam helper in ariane_pkg.
- One natural sub-module: rr_arbiter_oh. Combinational round-robin pick from a pointer, producing a one-hot output and an index.
- FSM, watchdog and ID capture stay in shared_fu_arbiter.

Test Plan:
- Single request:
  - Stimulus: NR_REQ=2, req_valid_i=01, id0=5, fu_ready_i=1; fu_done_i after 4 cycles.
  - Required: req_ready_o=01 and fu_valid_o=1 in cycle 0; then busy_o=1; wb_valid_o=1 with wb_trans_id_o=5 in the done cycle.
- Round-robin fairness:
  - Stimulus: req_valid_i=11 held continuously, each op completing after 2 cycles.
  - Required: grants alternate 01,10,01,10; each grant comes one cycle after the previous done.
- Backpressure:
  - Stimulus: req_valid_i=10 with fu_ready_i=0 for 3 cycles, then 1.
  - Required: req_ready_o=00 for 3 cycles, then 10.
- Flush in flight:
  - Stimulus: grant id=3, flush_i at BUSY cycle 1, fu_done_i 2 cycles later.
  - Required: fu_kill_o pulses once; wb_valid_o stays 0; FSM returns to IDLE; a new request is granted the following cycle.
- Flush coincident with done:
  - Stimulus: flush_i and fu_done_i asserted in the same BUSY cycle.
  - Required: wb_valid_o=0, fu_kill_o=0, next state IDLE.
- Watchdog and reset:
  - Stimulus: LAT_MAX=8, no fu_done_i.
  - Required: timeout_o=1 from BUSY cycle 8 onward. Asserting rst_i mid-BUSY clears timeout_o, busy_o and all outputs immediately, asynchronously.
